// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core MEM stage and the loader/DMA port.
// Define DMEM_ARB_CORE_PRIO_EN for fixed core priority; otherwise requesters are served round-robin.
module dmem_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wd,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          c_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wd,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

  state_t state;
  logic   ownerD;
  logic   ownWe;
  logic   ownErr;
`ifndef DMEM_ARB_CORE_PRIO_EN
  logic   lastD;
`endif

  logic          cElig;
  logic          dElig;
  logic          anyElig;
  logic          winD;
  logic          winWe;
  logic          winInRange;
  logic [AW-1:0] winAddr;
  logic [DW-1:0] winWd;

  // A requester is masked during its grant cycle so a held request is never captured twice.
  always_comb begin
    cElig   = c_req & ~c_gnt;
    dElig   = d_req & ~d_gnt;
    anyElig = cElig | dElig;
`ifdef DMEM_ARB_CORE_PRIO_EN
    winD    = ~cElig;
`else
    winD    = (cElig & dElig) ? ~lastD : dElig;
`endif
    winAddr    = winD ? d_addr : c_addr;
    winWd      = winD ? d_wd   : c_wd;
    winWe      = winD ? d_we   : c_we;
    winInRange = winAddr < LIMIT;
  end

  // Completion of the access in flight and capture of the next one can share an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ownerD   <= 1'b0;
      ownWe    <= 1'b0;
      ownErr   <= 1'b0;
`ifndef DMEM_ARB_CORE_PRIO_EN
      lastD    <= 1'b1;
`endif
      c_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
      c_err    <= 1'b0;
      d_err    <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      mem_we   <= 1'b0;
    end else begin
      c_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
      c_err    <= 1'b0;
      d_err    <= 1'b0;
      mem_we   <= 1'b0;

      if (state == ACCESS) begin
        if (ownerD) begin
          d_rvalid <= 1'b1;
          d_rdata  <= (ownErr | ownWe) ? '0 : mem_rd;
          d_err    <= ownErr;
        end else begin
          c_rvalid <= 1'b1;
          c_rdata  <= (ownErr | ownWe) ? '0 : mem_rd;
          c_err    <= ownErr;
        end
      end

      if (anyElig) begin
        mem_addr <= winAddr;
        mem_wd   <= winWd;
        mem_we   <= winWe & winInRange;
        c_gnt    <= ~winD;
        d_gnt    <= winD;
        ownerD   <= winD;
        ownWe    <= winWe;
        ownErr   <= ~winInRange;
`ifndef DMEM_ARB_CORE_PRIO_EN
        lastD    <= winD;
`endif
      end

      state <= anyElig ? ACCESS : IDLE;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model
// of the arbitration rules, with a 64-word memory behaving like the real data memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wd, d_addr, d_wd;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.AW(32), .DW(32), .DEPTH(64)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: writes commit on the negedge, reads are combinational.
  logic [31:0] memArr [64] = '{default: 32'h0};
  always @(negedge clk) if (mem_we) memArr[mem_addr[5:0]] <= mem_wd;
  assign mem_rd = memArr[mem_addr[5:0]];

  // Transaction-level reference: one pending access, a shadow memory and the last winner.
  logic [31:0] shadow [64] = '{default: 32'h0};
  logic        mGntC, mGntD, mLastD;
  logic        pendValid, pendD, pendWe, pendErr;
  logic [5:0]  pendAddr;
  logic [31:0] pendWd;
  logic        eRvC, eRvD, eErrC, eErrD, eMemWe;
  logic [31:0] eRdC, eRdD, eMemAddr, eMemWd;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mGntC = 0; mGntD = 0; mLastD = 1;
    pendValid = 0; pendD = 0; pendWe = 0; pendErr = 0; pendAddr = 0; pendWd = 0;
    eRvC = 0; eRvD = 0; eErrC = 0; eErrD = 0; eMemWe = 0;
    eRdC = 0; eRdD = 0; eMemAddr = 0; eMemWd = 0;
  endtask

  task automatic modelEdge();
    logic        ce, de, winD, inr;
    logic [31:0] val, addr;
    eRvC = 0; eRvD = 0; eErrC = 0; eErrD = 0; eRdC = 0; eRdD = 0;
    if (pendValid) begin
      val = 0;
      if (!pendErr && pendWe) shadow[pendAddr] = pendWd;
      if (!pendErr && !pendWe) val = shadow[pendAddr];
      if (pendD) begin eRvD = 1; eRdD = val; eErrD = pendErr; end
      else       begin eRvC = 1; eRdC = val; eErrC = pendErr; end
    end
    ce = c_req && !mGntC;
    de = d_req && !mGntD;
    mGntC = 0; mGntD = 0; eMemWe = 0; pendValid = 0;
    if (ce || de) begin
`ifdef DMEM_ARB_CORE_PRIO_EN
      winD = ce ? 1'b0 : 1'b1;
`else
      if (ce && de) winD = mLastD ? 1'b0 : 1'b1;
      else          winD = de;
`endif
      addr     = winD ? d_addr : c_addr;
      inr      = addr < 64;
      eMemAddr = addr;
      eMemWd   = winD ? d_wd : c_wd;
      eMemWe   = (winD ? d_we : c_we) && inr;
      if (winD) mGntD = 1; else mGntC = 1;
      mLastD    = winD;
      pendValid = 1;
      pendD     = winD;
      pendWe    = winD ? d_we : c_we;
      pendErr   = !inr;
      pendAddr  = addr[5:0];
      pendWd    = eMemWd;
    end
  endtask

  task automatic checkAll();
    checkOutput("c_gnt",    c_gnt,    mGntC);
    checkOutput("d_gnt",    d_gnt,    mGntD);
    checkOutput("c_rvalid", c_rvalid, eRvC);
    checkOutput("d_rvalid", d_rvalid, eRvD);
    checkOutput("c_rdata",  c_rdata,  eRdC);
    checkOutput("d_rdata",  d_rdata,  eRdD);
    checkOutput("c_err",    c_err,    eErrC);
    checkOutput("d_err",    d_err,    eErrD);
    checkOutput("mem_we",   mem_we,   eMemWe);
    checkOutput("mem_addr", mem_addr, eMemAddr);
    checkOutput("mem_wd",   mem_wd,   eMemWd);
  endtask

  task automatic edgeAndCheck();
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic applyStimulus();
    edgeAndCheck();
    @(negedge clk);
  endtask

  task automatic setCore(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    c_req = req; c_we = we; c_addr = addr; c_wd = wd;
  endtask

  task automatic setDma(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    d_req = req; d_we = we; d_addr = addr; d_wd = wd;
  endtask

  task automatic doReset();
    reset = 1;
    setCore(0, 0, 0, 0);
    setDma(0, 0, 0, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic cPend, dPend;

    // Reset state, then a core write followed by a read of the same word.
    doReset();
    setCore(1, 1, 5, 32'hDEADBEEF);
    applyStimulus();
    checkOutput("wr_gnt", c_gnt, 1);
    setCore(0, 0, 0, 0);
    applyStimulus();
    setCore(1, 0, 5, 0);
    applyStimulus();
    checkOutput("rd_gnt", c_gnt, 1);
    setCore(0, 0, 0, 0);
    applyStimulus();
    checkOutput("rd_rvalid", c_rvalid, 1);
    checkOutput("rd_rdata",  c_rdata,  32'hDEADBEEF);
    checkOutput("rd_err",    c_err,    0);

    // Simultaneous requests; the loser keeps its request up.
    doReset();
    setCore(1, 0, 1, 0);
    setDma(1, 0, 2, 0);
    applyStimulus();
    checkOutput("tie1_c", c_gnt, 1);
    setCore(0, 0, 0, 0);
    applyStimulus();
    checkOutput("tie1_d", d_gnt, 1);
    setDma(0, 0, 0, 0);
    applyStimulus();
    setCore(1, 0, 3, 0);
    applyStimulus();
    setCore(0, 0, 0, 0);
    applyStimulus();
    setCore(1, 0, 1, 0);
    setDma(1, 0, 2, 0);
    applyStimulus();
`ifdef DMEM_ARB_CORE_PRIO_EN
    checkOutput("tie2_c", c_gnt, 1);
    setCore(0, 0, 0, 0);
`else
    checkOutput("tie2_d", d_gnt, 1);
    setDma(0, 0, 0, 0);
`endif
    applyStimulus();
    setCore(0, 0, 0, 0);
    setDma(0, 0, 0, 0);
    repeat (2) applyStimulus();

    // Out-of-range DMA read.
    setDma(1, 0, 64, 0);
    applyStimulus();
    checkOutput("oor_gnt", d_gnt, 1);
    checkOutput("oor_we",  mem_we, 0);
    setDma(0, 0, 0, 0);
    applyStimulus();
    checkOutput("oor_rvalid", d_rvalid, 1);
    checkOutput("oor_rdata",  d_rdata,  0);
    checkOutput("oor_err",    d_err,    1);

    // Both ports held continuously with a fresh command after every grant.
    setCore(1, 1, 16, $urandom);
    setDma(1, 0, 17, 0);
    for (int i = 0; i < 8; i++) begin
      edgeAndCheck();
      checkOutput("alt_gnt", c_gnt | d_gnt, 1);
      @(negedge clk);
      if (mGntC) setCore(1, 1'($urandom), 32'($urandom_range(16, 31)), $urandom);
      if (mGntD) setDma(1, 1'($urandom), 32'($urandom_range(16, 31)), $urandom);
    end
    setCore(0, 0, 0, 0);
    setDma(0, 0, 0, 0);
    repeat (2) applyStimulus();

    // Reset lands in the access cycle of a core write, before the memory negedge.
    setCore(1, 1, 7, 32'hCAFEF00D);
    edgeAndCheck();
    checkOutput("rst_gnt_pre", c_gnt,  1);
    checkOutput("rst_we_pre",  mem_we, 1);
    #2;
    reset = 1;
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    setCore(0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("rst_rvalid", c_rvalid, 0);
    @(negedge clk);
    reset = 0;
    setCore(1, 0, 7, 0);
    applyStimulus();
    setCore(0, 0, 0, 0);
    applyStimulus();
    checkOutput("rst_rd_valid", c_rvalid, 1);
    checkOutput("rst_rd_data",  c_rdata,  0);

    // Randomized traffic from both ports, including out-of-range addresses.
    cPend = 0;
    dPend = 0;
    for (int i = 0; i < 400; i++) begin
      if (cPend && mGntC) cPend = 0;
      if (!cPend && $urandom_range(0, 1) == 1) begin
        cPend = 1;
        setCore(1, 1'($urandom),
                ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 71)), $urandom);
      end
      c_req = cPend;
      if (dPend && mGntD) dPend = 0;
      if (!dPend && $urandom_range(0, 1) == 1) begin
        dPend = 1;
        setDma(1, 1'($urandom),
               ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 71)), $urandom);
      end
      d_req = dPend;
      applyStimulus();
    end
    setCore(0, 0, 0, 0);
    setDma(0, 0, 0, 0);
    repeat (3) applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port 64-word data memory. Shares the memory between the pipeline MEM stage (core port `c_*`) and a loader/DMA port (`d_*`). Registers the winning command onto the memory pins, returns read data with a one-cycle valid pulse, and rejects out-of-range addresses. Sits between the MEM stage / loader and the data memory instance.

## Interface
- `AW`, 32: address width, both ports and memory side
- `DW`, 32: data width
- `DEPTH`, 64: number of memory words; word address `>= DEPTH` is out of range
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-high reset
- `c_req`, `d_req`  in  1  request; held with command stable until the matching `gnt` is seen
- `c_we`, `d_we`  in  1  1 = write, 0 = read
- `c_addr`, `d_addr`  in  AW  word address
- `c_wd`, `d_wd`  in  DW  write data
- `c_gnt`, `d_gnt`  out  1  one-cycle pulse; command was accepted at the preceding edge
- `c_rvalid`, `d_rvalid`  out  1  one-cycle pulse; access completed
- `c_rdata`, `d_rdata`  out  DW  read data, valid with `rvalid`; 0 for writes and errors
- `c_err`, `d_err`  out  1  with `rvalid`; address out of range
- `mem_addr`  out  AW  to memory `Address`
- `mem_wd`  out  DW  to memory `WD`
- `mem_we`  out  1  to memory `WE`
- `mem_rd`  in  DW  from memory `RD`

## Operation
- FSM states: `IDLE`, `ACCESS`.
  - `IDLE` → `ACCESS` on any eligible request.
  - `ACCESS` → `ACCESS` if another eligible request exists, else → `IDLE`.
- Eligible means `x_req=1` and `x_gnt=0` in the current cycle. This masks the requester's hold cycle so one request is never captured twice.
- Arbitration: round-robin. A 1-bit `last` register records the last winner. When both are eligible, the port that is not `last` wins. A single eligible port always wins.
- On capture at a posedge:
  - Winner's `addr`/`wd` are registered onto `mem_addr`/`mem_wd`.
  - `mem_we` is set to `x_we` AND in-range.
  - `x_gnt` is set to 1.
  - `last` is updated.
  - The owner tag and error flag are registered.
- Out-of-range command (`addr >= DEPTH`):
  - Still granted.
  - `mem_we` is forced to 0.
  - Completes with `rdata=0` and `err=1`.
- Completion: at the posedge ending an `ACCESS` cycle, the owner's `rvalid` pulses for one cycle.
  - `rdata = mem_rd` for an in-range read, else 0.
  - `err` is set only for out-of-range.
  - The non-owner's `rvalid`, `rdata` and `err` stay 0.
- In `IDLE` and when no new capture occurs, `mem_we` is 0; `mem_addr` and `mem_wd` hold their last value.
- Reset, including mid-access:
  - State → `IDLE`; `last` → d, so the core wins the first tie.
  - All outputs → 0, including `mem_we`, so no write commits on the following memory negedge.
  - The in-flight access is dropped with no `rvalid`.

## Timing
- Edge E0: request captured. Cycle E0–E1: `gnt`=1 and `mem_*` driven.
- A write commits at the memory's negedge inside E0–E1.
- Read: memory output is combinational and sampled at E1. `rvalid` and `rdata` are high in cycle E1–E2.
- Latency from request-visible edge to `rvalid`: 2 edges.
- Throughput: 1 access per cycle when the two ports alternate. A single port issues at most one access per 2 cycles because of its hold cycle.
- Simultaneous completion of access N (`rvalid`) and capture of access N+1 (`gnt`) in the same cycle is legal, including on different ports.
- `gnt` is never high on both ports in the same cycle. `rvalid` is never high on both ports in the same cycle.

## Configuration
- `DMEM_ARB_CORE_PRIO_EN`
  - Defined: fixed priority. The core port wins whenever it is eligible; `last` is unused. The DMA port may starve under back-to-back core traffic, which is accepted.
  - Undefined: round-robin as described under Operation.

## Test plan
- Reset released. Core writes `addr=5`, `wd=0xDEADBEEF`, then reads `addr=5`:
  - `c_gnt` pulses one cycle after each request.
  - The read returns `c_rvalid=1`, `c_rdata=0xDEADBEEF`, `c_err=0`.
- Both ports request in the same cycle, core `addr=1`, DMA `addr=2`, both held after a loss:
  - Core is granted first, DMA the next cycle.
  - A repeated tie then grants DMA first.
  - With `DMEM_ARB_CORE_PRIO_EN`, core wins both ties.
- DMA reads `addr=64`:
  - `d_gnt` pulses.
  - `mem_we` stays 0.
  - `d_rvalid=1`, `d_rdata=0`, `d_err=1`.
- Alternating core/DMA requests held continuously for 8 cycles:
  - A `gnt` occurs every cycle.
  - `rvalid` is routed to the correct port with the correct data.
  - No request is captured twice.
- Assert `reset` during the `ACCESS` cycle of a core write to `addr=7`:
  - All outputs go to 0 immediately.
  - No `c_rvalid` is produced.
  - A later read of `addr=7` returns 0.
